dsp_aw_channel: RTL and testbench
=================================

Name: dsp_aw_channel

Overview:
AW-channel dispatcher of one master port in the interconnect; it sits directly upstream of the WDATA dispatcher.
- Master side: registers the master's write-address requests.
- Slave side: decodes the target slave from the address and presents the request to that slave's arbitration.
- Ordering: records each accepted burst as {slave ID, AWLEN} in an in-order FIFO.
- WDATA steering: the FIFO head drives the WDATA dispatcher's slave select and disable. The entry retires when the W beat count reaches AWLEN+1.

Parameters:
- SLV_AMT, 2, number of slaves; must equal 2**SLV_ID_W.
- OUTST_AMT, 4, depth of the ordering FIFO (power of two, ≥2).
- ADDR_WIDTH, 32, AWADDR width.
- TRANS_MST_ID_W, 5, AWID width.
- TRANS_BURST_W, 2, AWBURST width.
- TRANS_DATA_LEN_W, 8, AWLEN width.
- TRANS_DATA_SIZE_W, 3, AWSIZE width.
- SLV_ID_MSB_IDX, 30, address MSB of the slave-ID field.
- SLV_ID_LSB_IDX, 30, address LSB of the slave-ID field.
- SLV_ID_W, SLV_ID_MSB_IDX-SLV_ID_LSB_IDX+1, slave-ID width.

Ports:
- ACLK_i  in  1  clock, rising edge.
- ARESETn_i  in  1  asynchronous active-low reset.
- m_AWID_i  in  TRANS_MST_ID_W  master AWID.
- m_AWADDR_i  in  ADDR_WIDTH  master AWADDR.
- m_AWBURST_i  in  TRANS_BURST_W  master AWBURST.
- m_AWLEN_i  in  TRANS_DATA_LEN_W  master AWLEN (beats-1).
- m_AWSIZE_i  in  TRANS_DATA_SIZE_W  master AWSIZE.
- m_AWVALID_i  in  1  master AWVALID.
- m_AWREADY_o  out  1  AWREADY to master.
- sa_AWID_o  out  TRANS_MST_ID_W*SLV_AMT  AWID broadcast, one slice per slave.
- sa_AWADDR_o  out  ADDR_WIDTH*SLV_AMT  AWADDR broadcast.
- sa_AWBURST_o  out  TRANS_BURST_W*SLV_AMT  AWBURST broadcast.
- sa_AWLEN_o  out  TRANS_DATA_LEN_W*SLV_AMT  AWLEN broadcast.
- sa_AWSIZE_o  out  TRANS_DATA_SIZE_W*SLV_AMT  AWSIZE broadcast.
- sa_AWVALID_o  out  SLV_AMT  per-slave AWVALID; at most one bit set.
- sa_AWREADY_i  in  SLV_AMT  per-slave AWREADY from slave arbitration.
- dsp_WDATA_WVALID_i  in  1  W beat valid from WDATA dispatcher.
- dsp_WDATA_WREADY_i  in  1  W beat ready from WDATA dispatcher (already gated by disable).
- dsp_WDATA_slv_id_o  out  SLV_ID_W  slave ID of the burst at FIFO head.
- dsp_WDATA_disable_o  out  1  1 = no burst outstanding; WDATA must stall.

Behaviour:
- Reset (asynchronous, any time, including mid-burst):
  - skid buffer and FIFO empty, beat counter 0;
  - m_AWREADY_o=1, sa_AWVALID_o=0, dsp_WDATA_disable_o=1, dsp_WDATA_slv_id_o=0;
  - any in-flight burst is discarded.
- Input stage: 2-entry skid buffer on {AWID,AWADDR,AWBURST,AWLEN,AWSIZE}.
  - m_AWREADY_o is registered; it is 0 only when both entries are occupied.
  - Accept at cycle N → request visible at the slave side at N+1, at the earliest.
  - Full throughput of 1 AW/cycle when downstream is ready.
- Decode: slv_id = head.AWADDR[SLV_ID_MSB_IDX:SLV_ID_LSB_IDX], one-hot to sel.
- Slave side:
  - all slices of the sa_AW* payload outputs carry the head payload;
  - sa_AWVALID_o[k] = fwd_valid & ~fifo_full & sel[k];
  - fwd_ready = sa_AWREADY_i[slv_id] & ~fifo_full;
  - AW fire = fwd_valid & fwd_ready → skid pop plus FIFO push of {slv_id, AWLEN}.
- Valid stability: once sa_AWVALID_o[k] rises it holds until fire. Full cannot newly assert without a push, and a push requires fire.
- FIFO: OUTST_AMT entries, wrap-around pointers with an extra wrap bit; full when the MSBs differ and the rest are equal.
  - dsp_WDATA_disable_o = fifo_empty.
  - dsp_WDATA_slv_id_o = head.slv_id.
  - No bypass: a push into an empty FIFO deasserts disable on the next cycle.
- Beat counter (width TRANS_DATA_LEN_W):
  - W fire = dsp_WDATA_WVALID_i & dsp_WDATA_WREADY_i, ignored when empty;
  - on W fire: if cnt==head.len, pop the FIFO and clear cnt to 0; else cnt+1;
  - AWLEN=0 pops on the first beat.
- Simultaneous events:
  - Push and pop in the same cycle: both take effect and the occupancy is unchanged.
  - FIFO full with pop this cycle: the push is still blocked, because ready uses the registered full.
  - Pop of the last entry with a simultaneous push: disable stays 0 and slv_id switches to the new head next cycle.
- Back-to-back bursts: the head pops on the last beat. The next head's slv_id/disable are valid in the following cycle, so W may proceed without a bubble beyond the pop edge.

Test Plan:
1. AWADDR=0x4000_0000, AWLEN=3, sa_AWREADY_i=2'b11 →
   - sa_AWVALID_o=2'b10 one cycle after acceptance;
   - disable_o 1→0, slv_id_o=1;
   - after 4 W fires, disable_o=1.
2. Four AWs (AWLEN=0) with no W traffic, OUTST_AMT=4 → fifth AW holds sa_AWVALID_o=0 until one W fire; then the fifth AW fires in the next cycle.
3. AW to slave 0 (AWLEN=1) then slave 1 (AWLEN=0) → slv_id_o=0 for 2 beats, then 1 for 1 beat, then disable_o=1.
4. sa_AWREADY_i=0 for 10 cycles with the master streaming →
   - m_AWREADY_o drops after 2 accepts;
   - payload and sa_AWVALID_o are stable throughout.
5. Reset asserted mid-burst (cnt=2 of AWLEN=5) → outputs immediately return to reset values; after release the first W fire counts from 0.
6. FIFO holds 1 entry with AWLEN=0; last W beat and AW fire in the same cycle → disable_o stays 0, and slv_id_o shows the new entry on the next cycle.

Source files
------------

// File: rtl/dsp_aw_channel.sv
// AW-channel dispatcher for one master port: skid-buffers write-address requests,
// routes them to the decoded slave and keeps burst order for WDATA steering.
module dsp_aw_channel #(
    parameter int SLV_AMT           = 2,
    parameter int OUTST_AMT         = 4,
    parameter int ADDR_WIDTH        = 32,
    parameter int TRANS_MST_ID_W    = 5,
    parameter int TRANS_BURST_W     = 2,
    parameter int TRANS_DATA_LEN_W  = 8,
    parameter int TRANS_DATA_SIZE_W = 3,
    parameter int SLV_ID_MSB_IDX    = 30,
    parameter int SLV_ID_LSB_IDX    = 30,
    parameter int SLV_ID_W          = SLV_ID_MSB_IDX - SLV_ID_LSB_IDX + 1
) (
    input  logic                                  ACLK_i,
    input  logic                                  ARESETn_i,
    input  logic [TRANS_MST_ID_W-1:0]             m_AWID_i,
    input  logic [ADDR_WIDTH-1:0]                 m_AWADDR_i,
    input  logic [TRANS_BURST_W-1:0]              m_AWBURST_i,
    input  logic [TRANS_DATA_LEN_W-1:0]           m_AWLEN_i,
    input  logic [TRANS_DATA_SIZE_W-1:0]          m_AWSIZE_i,
    input  logic                                  m_AWVALID_i,
    output logic                                  m_AWREADY_o,
    output logic [TRANS_MST_ID_W*SLV_AMT-1:0]     sa_AWID_o,
    output logic [ADDR_WIDTH*SLV_AMT-1:0]         sa_AWADDR_o,
    output logic [TRANS_BURST_W*SLV_AMT-1:0]      sa_AWBURST_o,
    output logic [TRANS_DATA_LEN_W*SLV_AMT-1:0]   sa_AWLEN_o,
    output logic [TRANS_DATA_SIZE_W*SLV_AMT-1:0]  sa_AWSIZE_o,
    output logic [SLV_AMT-1:0]                    sa_AWVALID_o,
    input  logic [SLV_AMT-1:0]                    sa_AWREADY_i,
    input  logic                                  dsp_WDATA_WVALID_i,
    input  logic                                  dsp_WDATA_WREADY_i,
    output logic [SLV_ID_W-1:0]                   dsp_WDATA_slv_id_o,
    output logic                                  dsp_WDATA_disable_o
);

    localparam int PTR_W = $clog2(OUTST_AMT);
    localparam int PL_W  = TRANS_MST_ID_W + ADDR_WIDTH + TRANS_BURST_W
                         + TRANS_DATA_LEN_W + TRANS_DATA_SIZE_W;

    logic [PL_W-1:0]             skid_mem_r [2];
    logic                        skid_wr_ptr_r;
    logic                        skid_rd_ptr_r;
    logic [1:0]                  skid_cnt_r;
    logic [1:0]                  skid_cnt_nxt_s;
    logic                        aw_ready_r;
    logic                        m_accept_s;

    logic [TRANS_MST_ID_W-1:0]    head_id_s;
    logic [ADDR_WIDTH-1:0]        head_addr_s;
    logic [TRANS_BURST_W-1:0]     head_burst_s;
    logic [TRANS_DATA_LEN_W-1:0]  head_len_s;
    logic [TRANS_DATA_SIZE_W-1:0] head_size_s;
    logic [SLV_ID_W-1:0]          slv_id_s;
    logic [SLV_AMT-1:0]           sel_s;
    logic                         fwd_valid_s;
    logic                         fwd_ready_s;
    logic                         aw_fire_s;

    logic [SLV_ID_W-1:0]          fifo_id_r  [OUTST_AMT];
    logic [TRANS_DATA_LEN_W-1:0]  fifo_len_r [OUTST_AMT];
    logic [PTR_W:0]               fifo_wr_ptr_r;
    logic [PTR_W:0]               fifo_rd_ptr_r;
    logic                         fifo_full_s;
    logic                         fifo_empty_s;
    logic [TRANS_DATA_LEN_W-1:0]  beat_cnt_r;
    logic                         w_fire_s;
    logic                         fifo_pop_s;

    assign m_accept_s  = m_AWVALID_i & aw_ready_r;
    assign m_AWREADY_o = aw_ready_r;
    assign fwd_valid_s = (skid_cnt_r != 2'd0);
    assign {head_id_s, head_addr_s, head_burst_s, head_len_s, head_size_s} = skid_mem_r[skid_rd_ptr_r];
    assign slv_id_s    = head_addr_s[SLV_ID_MSB_IDX:SLV_ID_LSB_IDX];

    // One-hot slave select from the decoded slave ID
    always_comb begin
        sel_s           = '0;
        sel_s[slv_id_s] = 1'b1;
    end

    // Ready is gated by the registered full flag so valid never drops without a fire
    assign fwd_ready_s  = sa_AWREADY_i[slv_id_s] & ~fifo_full_s;
    assign aw_fire_s    = fwd_valid_s & fwd_ready_s;
    assign sa_AWVALID_o = {SLV_AMT{fwd_valid_s & ~fifo_full_s}} & sel_s;
    assign sa_AWID_o    = {SLV_AMT{head_id_s}};
    assign sa_AWADDR_o  = {SLV_AMT{head_addr_s}};
    assign sa_AWBURST_o = {SLV_AMT{head_burst_s}};
    assign sa_AWLEN_o   = {SLV_AMT{head_len_s}};
    assign sa_AWSIZE_o  = {SLV_AMT{head_size_s}};

    // Skid occupancy after this cycle's accept/fire
    always_comb begin
        case ({m_accept_s, aw_fire_s})
            2'b10:   skid_cnt_nxt_s = skid_cnt_r + 2'd1;
            2'b01:   skid_cnt_nxt_s = skid_cnt_r - 2'd1;
            default: skid_cnt_nxt_s = skid_cnt_r;
        endcase
    end

    // Two-entry skid buffer with registered ready
    always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
        if (!ARESETn_i) begin
            skid_mem_r[0] <= '0;
            skid_mem_r[1] <= '0;
            skid_wr_ptr_r <= 1'b0;
            skid_rd_ptr_r <= 1'b0;
            skid_cnt_r    <= 2'd0;
            aw_ready_r    <= 1'b1;
        end else begin
            skid_cnt_r <= skid_cnt_nxt_s;
            aw_ready_r <= (skid_cnt_nxt_s != 2'd2);
            if (m_accept_s) begin
                skid_mem_r[skid_wr_ptr_r] <= {m_AWID_i, m_AWADDR_i, m_AWBURST_i, m_AWLEN_i, m_AWSIZE_i};
                skid_wr_ptr_r             <= ~skid_wr_ptr_r;
            end
            if (aw_fire_s) begin
                skid_rd_ptr_r <= ~skid_rd_ptr_r;
            end
        end
    end

    assign fifo_empty_s = (fifo_wr_ptr_r == fifo_rd_ptr_r);
    assign fifo_full_s  = (fifo_wr_ptr_r[PTR_W] != fifo_rd_ptr_r[PTR_W]) &&
                          (fifo_wr_ptr_r[PTR_W-1:0] == fifo_rd_ptr_r[PTR_W-1:0]);
    assign w_fire_s     = dsp_WDATA_WVALID_i & dsp_WDATA_WREADY_i & ~fifo_empty_s;
    assign fifo_pop_s   = w_fire_s & (beat_cnt_r == fifo_len_r[fifo_rd_ptr_r[PTR_W-1:0]]);

    assign dsp_WDATA_slv_id_o  = fifo_id_r[fifo_rd_ptr_r[PTR_W-1:0]];
    assign dsp_WDATA_disable_o = fifo_empty_s;

    // Ordering FIFO of {slave ID, AWLEN} and the W beat counter of the head burst
    always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
        if (!ARESETn_i) begin
            for (int i = 0; i < OUTST_AMT; i++) begin
                fifo_id_r[i]  <= '0;
                fifo_len_r[i] <= '0;
            end
            fifo_wr_ptr_r <= '0;
            fifo_rd_ptr_r <= '0;
            beat_cnt_r    <= '0;
        end else begin
            if (aw_fire_s) begin
                fifo_id_r[fifo_wr_ptr_r[PTR_W-1:0]]  <= slv_id_s;
                fifo_len_r[fifo_wr_ptr_r[PTR_W-1:0]] <= head_len_s;
                fifo_wr_ptr_r                        <= fifo_wr_ptr_r + (PTR_W+1)'(1);
            end
            if (fifo_pop_s) begin
                fifo_rd_ptr_r <= fifo_rd_ptr_r + (PTR_W+1)'(1);
                beat_cnt_r    <= '0;
            end else if (w_fire_s) begin
                beat_cnt_r <= beat_cnt_r + TRANS_DATA_LEN_W'(1);
            end else begin
                beat_cnt_r <= beat_cnt_r;
            end
        end
    end

endmodule

// File: tb/tb_dsp_aw_channel.sv
// Directed bench for dsp_aw_channel: vector table plus hand sequences for
// FIFO-full, slave back-pressure and mid-burst reset.
module tb_dsp_aw_channel;

    logic        clk;
    logic        rst_n;
    logic [4:0]  awid;
    logic [31:0] awaddr;
    logic [1:0]  awburst;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic        awvalid;
    logic        awready;
    logic [9:0]  sa_awid;
    logic [63:0] sa_awaddr;
    logic [3:0]  sa_awburst;
    logic [15:0] sa_awlen;
    logic [5:0]  sa_awsize;
    logic [1:0]  sa_awvalid;
    logic [1:0]  sa_awready;
    logic        wvalid;
    logic        wready;
    logic        slv_id;
    logic        dis;

    int n_checks = 0;
    int n_fail   = 0;

    dsp_aw_channel dut (
        .ACLK_i              (clk),
        .ARESETn_i           (rst_n),
        .m_AWID_i            (awid),
        .m_AWADDR_i          (awaddr),
        .m_AWBURST_i         (awburst),
        .m_AWLEN_i           (awlen),
        .m_AWSIZE_i          (awsize),
        .m_AWVALID_i         (awvalid),
        .m_AWREADY_o         (awready),
        .sa_AWID_o           (sa_awid),
        .sa_AWADDR_o         (sa_awaddr),
        .sa_AWBURST_o        (sa_awburst),
        .sa_AWLEN_o          (sa_awlen),
        .sa_AWSIZE_o         (sa_awsize),
        .sa_AWVALID_o        (sa_awvalid),
        .sa_AWREADY_i        (sa_awready),
        .dsp_WDATA_WVALID_i  (wvalid),
        .dsp_WDATA_WREADY_i  (wready),
        .dsp_WDATA_slv_id_o  (slv_id),
        .dsp_WDATA_disable_o (dis)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        awv;
        logic [31:0] addr;
        logic [7:0]  len;
        logic        wv;
        logic        exp_rdy;
        logic [1:0]  exp_sa;
        logic        exp_dis;
        logic        chk_slv;
        logic        exp_slv;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // test 1: single burst to slave 1 with AWLEN=3
        vecs[0]  = '{1'b1, 32'h4000_0000, 8'd3, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0000, 8'd0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1};
        vecs[2]  = '{1'b0, 32'h0000_0000, 8'd0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1};
        vecs[3]  = '{1'b0, 32'h0000_0000, 8'd0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1};
        vecs[4]  = '{1'b0, 32'h0000_0000, 8'd0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 32'h0000_0000, 8'd0, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0};
        // test 3: slave 0 (AWLEN=1) then slave 1 (AWLEN=0)
        vecs[6]  = '{1'b1, 32'h0000_0000, 8'd1, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 32'h4000_0000, 8'd0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 32'h0000_0000, 8'd0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 32'h0000_0000, 8'd0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1};
        vecs[10] = '{1'b0, 32'h0000_0000, 8'd0, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 32'h0000_0000, 8'd0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0};
        // test 6: last beat of a single AWLEN=0 entry coincides with an AW fire
        vecs[12] = '{1'b1, 32'h0000_0000, 8'd0, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 32'h4000_0000, 8'd0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 32'h0000_0000, 8'd0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1};
        vecs[15] = '{1'b0, 32'h0000_0000, 8'd0, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 32'h0000_0000, 8'd0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0};

        rst_n      = 1'b0;
        awid       = 5'd7;
        awaddr     = 32'h0;
        awburst    = 2'd1;
        awlen      = 8'd0;
        awsize     = 3'd2;
        awvalid    = 1'b0;
        sa_awready = 2'b11;
        wvalid     = 1'b0;
        wready     = 1'b1;
        tick();
        tick();
        chk("reset_awready", 64'(awready), 64'(1'b1));
        chk("reset_sa_awvalid", 64'(sa_awvalid), 64'(2'b00));
        chk("reset_disable", 64'(dis), 64'(1'b1));
        chk("reset_slv_id", 64'(slv_id), 64'(1'b0));
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            awvalid = vecs[i].awv;
            awaddr  = vecs[i].addr;
            awlen   = vecs[i].len;
            wvalid  = vecs[i].wv;
            tick();
            chk($sformatf("vec%0d_awready", i), 64'(awready), 64'(vecs[i].exp_rdy));
            chk($sformatf("vec%0d_sa_awvalid", i), 64'(sa_awvalid), 64'(vecs[i].exp_sa));
            chk($sformatf("vec%0d_disable", i), 64'(dis), 64'(vecs[i].exp_dis));
            if (vecs[i].chk_slv)
                chk($sformatf("vec%0d_slv_id", i), 64'(slv_id), 64'(vecs[i].exp_slv));
        end

        // test 2: four AWLEN=0 bursts fill the FIFO, fifth waits for one W beat
        awaddr  = 32'h0;
        awlen   = 8'd0;
        awvalid = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        awvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("full_hold_sa_awvalid", 64'(sa_awvalid), 64'(2'b00));
            tick();
        end
        chk("full_disable", 64'(dis), 64'(1'b0));
        wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        chk("full_release_sa_awvalid", 64'(sa_awvalid), 64'(2'b01));
        tick();
        chk("full_fifth_fired", 64'(sa_awvalid), 64'(2'b00));
        wvalid = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("full_drain_not_done", 64'(dis), 64'(1'b0));
        tick();
        wvalid = 1'b0;
        chk("full_drain_done", 64'(dis), 64'(1'b1));

        // test 4: slave back-pressure for 10 cycles while the master streams
        sa_awready = 2'b00;
        awvalid    = 1'b1;
        for (int i = 0; i < 10; i++) begin
            awaddr = 32'h4000_0000 + 32'(i * 16);
            awlen  = 8'(i);
            awid   = 5'(i + 3);
            tick();
            chk($sformatf("bp%0d_awready", i), 64'(awready), 64'((i < 1) ? 1'b1 : 1'b0));
            chk($sformatf("bp%0d_sa_awvalid", i), 64'(sa_awvalid), 64'(2'b10));
            chk($sformatf("bp%0d_addr", i), sa_awaddr, 64'h4000_0000_4000_0000);
            chk($sformatf("bp%0d_len", i), 64'(sa_awlen), 64'(16'h0000));
            chk($sformatf("bp%0d_id", i), 64'(sa_awid), 64'({5'd3, 5'd3}));
        end
        awvalid    = 1'b0;
        sa_awready = 2'b11;
        tick();
        chk("bp_release_awready", 64'(awready), 64'(1'b1));
        chk("bp_second_addr", 64'(sa_awaddr[31:0]), 64'(32'h4000_0010));
        chk("bp_second_len", 64'(sa_awlen[15:8]), 64'(8'd1));
        tick();
        chk("bp_second_fired", 64'(sa_awvalid), 64'(2'b00));
        wvalid = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        wvalid = 1'b0;
        chk("bp_drain_done", 64'(dis), 64'(1'b1));

        // test 5: reset mid-burst at beat count 2 of AWLEN=5
        awaddr  = 32'h0;
        awlen   = 8'd5;
        awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        tick();
        wvalid = 1'b1;
        tick();
        tick();
        wvalid = 1'b0;
        chk("pre_reset_disable", 64'(dis), 64'(1'b0));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_awready", 64'(awready), 64'(1'b1));
        chk("async_reset_sa_awvalid", 64'(sa_awvalid), 64'(2'b00));
        chk("async_reset_disable", 64'(dis), 64'(1'b1));
        chk("async_reset_slv_id", 64'(slv_id), 64'(1'b0));
        tick();
        rst_n = 1'b1;
        awaddr  = 32'h4000_0000;
        awlen   = 8'd1;
        awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        tick();
        chk("post_reset_disable", 64'(dis), 64'(1'b0));
        chk("post_reset_slv_id", 64'(slv_id), 64'(1'b1));
        wvalid = 1'b1;
        tick();
        chk("post_reset_beat1", 64'(dis), 64'(1'b0));
        tick();
        wvalid = 1'b0;
        chk("post_reset_beat2_pop", 64'(dis), 64'(1'b1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
